// File: rtl/pipe_pkg.sv
// Shared pipeline-control definitions: IR field positions, opcode/aluop constants, FSM state type.
package pipe_pkg;

    localparam int unsigned OpMsb    = 31;
    localparam int unsigned OpLsb    = 27;
    localparam int unsigned RdMsb    = 26;
    localparam int unsigned RdLsb    = 22;
    localparam int unsigned RsMsb    = 21;
    localparam int unsigned RsLsb    = 17;
    localparam int unsigned RtMsb    = 16;
    localparam int unsigned RtLsb    = 12;
    localparam int unsigned AluopMsb = 6;
    localparam int unsigned AluopLsb = 2;

    localparam logic [4:0] OpcRtype = 5'b00000;
    localparam logic [4:0] OpcLw    = 5'b01000;
    localparam logic [4:0] AluMult  = 5'b00110;
    localparam logic [4:0] AluDiv   = 5'b00111;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StBusy = 2'b01,
        StDone = 2'b10
    } md_state_e;

    function automatic logic is_mult_div(input logic [31:0] ir);
        return (ir[OpMsb:OpLsb] == OpcRtype) &&
               ((ir[AluopMsb:AluopLsb] == AluMult) || (ir[AluopMsb:AluopLsb] == AluDiv));
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the F/D and D/X instruction registers.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic [31:0] fd_ir_i,
    input  logic [31:0] dx_ir_i,
    output logic        load_use_o
);

    logic [4:0] dx_rd;
    logic       dx_is_lw;
    logic       rs_match;
    logic       rt_match;

    assign dx_rd    = dx_ir_i[RdMsb:RdLsb];
    assign dx_is_lw = (dx_ir_i[OpMsb:OpLsb] == OpcLw) && (dx_rd != 5'd0);
    assign rs_match = fd_ir_i[RsMsb:RsLsb] == dx_rd;
    // rt is only a source operand for R-type instructions
    assign rt_match = (fd_ir_i[OpMsb:OpLsb] == OpcRtype) && (fd_ir_i[RtMsb:RtLsb] == dx_rd);

    assign load_use_o = dx_is_lw && (rs_match || rt_match);

    logic unused_ir;
    assign unused_ir = ^{fd_ir_i[RdMsb:RdLsb], fd_ir_i[RtLsb-1:0], dx_ir_i[RsMsb:0]};

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller with multdiv handshake FSM and saturating stall counter.
// Optional multdiv abort on timeout is enabled by defining MD_TIMEOUT_EN.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned MD_TIMEOUT = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] fd_ir,
    input  logic [31:0] dx_ir,
    input  logic        branch_taken,
    input  logic        md_ready,
    output logic        pc_we,
    output logic        fd_we,
    output logic        dx_we,
    output logic        xm_we,
    output logic        mw_we,
    output logic        fd_bubble,
    output logic        dx_bubble,
    output logic        xm_bubble,
    output logic        md_start,
    output logic        md_busy,
    output logic        md_timeout,
    output logic [15:0] stall_cnt
);

    md_state_e   state_q, state_d;
    logic [15:0] stall_cnt_q;
    logic        md_op;
    logic        md_stall;
    logic        load_use;
    logic        tmo_hit;

    assign md_op    = is_mult_div(dx_ir);
    assign md_stall = ((state_q == StIdle) && md_op) || (state_q == StBusy);

    hazard_detect u_hazard_detect (
        .fd_ir_i    (fd_ir),
        .dx_ir_i    (dx_ir),
        .load_use_o (load_use)
    );

`ifdef MD_TIMEOUT_EN
    localparam int unsigned TmoW = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;

    logic [TmoW-1:0] tmo_cnt_q;

    // Counter idles at zero outside BUSY, so it is already cleared on BUSY entry
    always_ff @(posedge clock) begin
        if (reset || (state_q != StBusy)) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    assign tmo_hit = (state_q == StBusy) && !md_ready && (tmo_cnt_q == TmoW'(MD_TIMEOUT - 1));
`else
    logic unused_cfg;
    assign unused_cfg = ^MD_TIMEOUT;
    assign tmo_hit    = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (md_op) state_d = StBusy;
            StBusy:  if (md_ready || tmo_hit) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        pc_we     = 1'b1;
        fd_we     = 1'b1;
        dx_we     = 1'b1;
        xm_we     = 1'b1;
        mw_we     = 1'b1;
        fd_bubble = 1'b0;
        dx_bubble = 1'b0;
        xm_bubble = 1'b0;
        md_start  = 1'b0;
        md_busy   = !reset && (state_q != StIdle);
        md_timeout = !reset && tmo_hit;
        // DONE releases the pipeline unconditionally so the finished op leaves D/X
        if (!reset && (state_q != StDone)) begin
            if (md_stall) begin
                pc_we     = 1'b0;
                fd_we     = 1'b0;
                dx_we     = 1'b0;
                xm_bubble = 1'b1;
                md_start  = (state_q == StIdle);
            end else if (branch_taken) begin
                fd_bubble = 1'b1;
                dx_bubble = 1'b1;
            end else if (load_use) begin
                pc_we     = 1'b0;
                fd_we     = 1'b0;
                dx_bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_q <= 16'h0000;
        end else if (!pc_we && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'h0001;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomised + directed bench for pipe_ctrl with a queue-based scoreboard and reference model.
module tb_pipe_ctrl;

    localparam int unsigned Tmo = 8;
`ifdef MD_TIMEOUT_EN
    localparam bit TmoEn = 1'b1;
`else
    localparam bit TmoEn = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] fd_ir, dx_ir;
    logic        branch_taken, md_ready;
    logic        pc_we, fd_we, dx_we, xm_we, mw_we;
    logic        fd_bubble, dx_bubble, xm_bubble;
    logic        md_start, md_busy, md_timeout;
    logic [15:0] stall_cnt;

    always #5 clock = ~clock;

    pipe_ctrl #(.MD_TIMEOUT(Tmo)) dut (
        .clock        (clock),
        .reset        (reset),
        .fd_ir        (fd_ir),
        .dx_ir        (dx_ir),
        .branch_taken (branch_taken),
        .md_ready     (md_ready),
        .pc_we        (pc_we),
        .fd_we        (fd_we),
        .dx_we        (dx_we),
        .xm_we        (xm_we),
        .mw_we        (mw_we),
        .fd_bubble    (fd_bubble),
        .dx_bubble    (dx_bubble),
        .xm_bubble    (xm_bubble),
        .md_start     (md_start),
        .md_busy      (md_busy),
        .md_timeout   (md_timeout),
        .stall_cnt    (stall_cnt)
    );

    logic [26:0] exp_q[$];
    string       tag_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    // Reference model: where the multdiv unit is and how many stall cycles were seen
    bit m_busy, m_done;
    int m_wait, m_cnt;

    function automatic logic [31:0] rtype(input int rd, rs, rt, alu);
        logic [31:0] ir;
        ir = 32'(rd) * (1 << 22) + 32'(rs) * (1 << 17) + 32'(rt) * (1 << 12) + 32'(alu) * 4;
        return ir;
    endfunction

    function automatic logic [31:0] itype(input int op, rd, rs, imm);
        logic [31:0] ir;
        ir = 32'(op) * (1 << 27) + 32'(rd) * (1 << 22) + 32'(rs) * (1 << 17) + 32'(imm);
        return ir;
    endfunction

    function automatic logic [31:0] rand_ir();
        int alus[4];
        alus = '{6, 7, 0, int'($urandom_range(0, 31))};
        case ($urandom_range(0, 3))
            0:       return rtype($urandom_range(0, 3), $urandom_range(0, 3),
                                  $urandom_range(0, 3), alus[$urandom_range(0, 3)]);
            1:       return itype(8, $urandom_range(0, 3), $urandom_range(0, 3),
                                  $urandom_range(0, 255));
            2:       return itype($urandom_range(0, 31), $urandom_range(0, 3),
                                  $urandom_range(0, 3), $urandom_range(0, 255));
            default: return $urandom();
        endcase
    endfunction

    task automatic cycle(input logic [31:0] fd, dx, input logic br, rdy, rst, input string tag);
        int  fop, frs, frt, dop, drd, dalu;
        bit  md, lu, idle;
        bit  pc, fw, dw, xw, mw, fb, db, xb, st, bz, to;
        fd_ir = fd; dx_ir = dx; branch_taken = br; md_ready = rdy; reset = rst;
        fop = int'(fd >> 27); frs = int'((fd >> 17) & 31); frt = int'((fd >> 12) & 31);
        dop = int'(dx >> 27); drd = int'((dx >> 22) & 31); dalu = int'((dx >> 2) & 31);
        md   = (dop == 0) && (dalu == 6 || dalu == 7);
        lu   = (dop == 8) && (drd != 0) && (frs == drd || (fop == 0 && frt == drd));
        idle = !m_busy && !m_done;
        {pc, fw, dw, xw, mw} = 5'b11111;
        {fb, db, xb, st, bz, to} = 6'b0;
        if (!rst) begin
            bz = !idle;
            to = TmoEn && m_busy && !rdy && (m_wait == Tmo - 1);
            if (m_done) begin
            end else if ((idle && md) || m_busy) begin
                {pc, fw, dw} = 3'b000; xb = 1'b1; st = idle;
            end else if (br) begin
                fb = 1'b1; db = 1'b1;
            end else if (lu) begin
                pc = 1'b0; fw = 1'b0; db = 1'b1;
            end
        end
        exp_q.push_back({pc, fw, dw, xw, mw, fb, db, xb, st, bz, to, 16'(m_cnt)});
        tag_q.push_back(tag);
        if (rst) begin
            m_busy = 0; m_done = 0; m_cnt = 0;
        end else begin
            if (!pc && m_cnt < 65535) m_cnt++;
            if (idle && md) begin
                m_busy = 1; m_wait = 0;
            end else if (m_busy) begin
                if (rdy || to) begin m_busy = 0; m_done = 1; end
                else m_wait++;
            end else if (m_done) begin
                m_done = 0;
            end
        end
        @(posedge clock); #1;
    endtask

    initial begin : monitor
        logic [26:0] e, act;
        string       t;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                act = {pc_we, fd_we, dx_we, xm_we, mw_we, fd_bubble, dx_bubble, xm_bubble,
                       md_start, md_busy, md_timeout, stall_cnt};
                n_checks++;
                if (act === e) n_pass++;
                else $display("FAIL %s: got ctl=%b cnt=%h, expected ctl=%b cnt=%h",
                              t, act[26:16], act[15:0], e[26:16], e[15:0]);
            end
        end
    end

    initial begin : stimulus
        logic [31:0] nop, mult, add5, rt5, lw5, lw0;
        nop  = 32'h0;
        mult = rtype(3, 1, 2, 6);
        add5 = rtype(7, 5, 1, 0);
        rt5  = rtype(7, 1, 5, 0);
        lw5  = itype(8, 5, 2, 0);
        lw0  = itype(8, 0, 5, 0);
        fd_ir = nop; dx_ir = nop; branch_taken = 0; md_ready = 0; reset = 1;
        repeat (2) @(posedge clock);
        #1;
        m_busy = 0; m_done = 0; m_wait = 0; m_cnt = 0;

        cycle(nop, nop, 1, 1, 1, "reset_outputs");
        cycle(nop, nop, 0, 0, 0, "normal");
        // mult with md_ready three cycles after the start pulse
        cycle(nop, mult, 0, 0, 0, "md_start");
        cycle(nop, mult, 0, 1 & 0, 0, "md_busy1");
        cycle(nop, mult, 0, 0, 0, "md_busy2");
        cycle(nop, mult, 0, 1, 0, "md_ready");
        cycle(nop, mult, 0, 0, 0, "md_done");
        cycle(nop, nop, 0, 1, 0, "md_after_cnt4");
        cycle(add5, lw5, 0, 0, 0, "load_use_rs");
        cycle(add5, lw0, 0, 0, 0, "lw_rd0");
        cycle(rt5, lw5, 0, 0, 0, "load_use_rt");
        cycle(add5, lw5, 1, 0, 0, "branch_over_lu");
        // reset in the middle of BUSY
        cycle(nop, mult, 0, 0, 0, "rst_start");
        cycle(nop, mult, 0, 0, 0, "rst_busy");
        cycle(nop, mult, 0, 0, 1, "rst_in_busy");
        cycle(nop, nop, 0, 0, 0, "post_rst");
        if (TmoEn) begin
            for (int i = 0; i < Tmo + 3; i++) cycle(nop, mult, 0, 0, 0, "timeout");
            cycle(nop, nop, 0, 0, 0, "timeout_after");
        end
        for (int i = 0; i < 3000; i++) begin
            cycle(rand_ir(), rand_ir(), ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 99) == 0), "random");
        end
        for (int i = 0; i < 80000 && m_cnt < 65535; i++) cycle(nop, mult, 0, 0, 0, "saturate");
        for (int i = 0; i < 20; i++) cycle(nop, mult, 0, 0, 0, "saturated_hold");
        cycle(nop, nop, 0, 0, 0, "saturated_end");

        @(negedge clock);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
